// File: rtl/bt_pipe_in_rx.sv
// bt_pipe_in_rx
// Receive end of the PC->FPGA block-throttled pipe. Whole host blocks of 32-bit
// words are buffered in an internal FIFO. ep_ready is raised only when a full
// block fits. Each word is unpacked into 4 bytes on a valid/ready stream, with
// the least significant byte first.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a block strobe; ep_ready may be high
//   RECV  | accepting the BLOCK_WORDS words of the current block
//
// Ports:
//   clk, reset        okClk, synchronous active-high reset
//   ep_write          okBTPipeIn write strobe, one word per high cycle
//   ep_dataout        okBTPipeIn word, valid while ep_write=1
//   ep_blockstrobe    okBTPipeIn block start pulse
//   ep_ready          space for a whole block and idle (registered)
//   out_data          byte stream data
//   out_valid         byte stream valid
//   out_ready         byte stream ready
//   level             FIFO occupancy in words (unpack register not counted)
//   block_count       completed blocks, wraps at 16 bits
//   proto_err         sticky protocol violation flag
module bt_pipe_in_rx #(
  parameter int DEPTH       = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ep_write,
  input  logic [31:0]              ep_dataout,
  input  logic                     ep_blockstrobe,
  output logic                     ep_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              block_count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] word_cnt;
  logic [31:0]   unp_word;
  logic [1:0]    unp_idx;

  logic          strobe_ok;
  logic          write_recv;
  logic          last_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          unp_accept;
  logic          unp_free;
  logic          proto_set;
  logic [LW-1:0] level_nxt;
  logic          ep_ready_nxt;

  assign fifo_full  = (level == LW'(DEPTH));
  assign fifo_empty = (level == '0);
  assign strobe_ok  = (state == IDLE) && ep_ready && ep_blockstrobe;
  assign write_recv = (state == RECV) && ep_write;
  assign last_word  = write_recv && (word_cnt == CW'(BLOCK_WORDS - 1));
  assign push       = write_recv && !fifo_full;

  // The unpacker can take a new word when empty, or when its last byte is
  // leaving this cycle, which keeps the byte stream free of bubbles.
  assign unp_accept = out_valid && out_ready;
  assign unp_free   = !out_valid || (unp_accept && (unp_idx == 2'd3));
  assign pop        = unp_free && !fifo_empty;

  assign level_nxt  = level + LW'(push) - LW'(pop);

  always_comb begin
    state_nxt = state;
    if (strobe_ok)
      state_nxt = RECV;
    else if (last_word)
      state_nxt = IDLE;
  end

  assign ep_ready_nxt = (state_nxt == IDLE) && (level_nxt <= LW'(DEPTH - BLOCK_WORDS));

  assign proto_set = (ep_blockstrobe && ((state == RECV) || !ep_ready))
                   || (ep_write && (state == IDLE))
                   || (write_recv && fifo_full);

  assign out_data = unp_word[{unp_idx, 3'b000} +: 8];

  // Storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ep_dataout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      word_cnt    <= '0;
      unp_word    <= '0;
      unp_idx     <= '0;
      out_valid   <= 1'b0;
      ep_ready    <= 1'b0;
      block_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      ep_ready <= ep_ready_nxt;

      if (proto_set)
        proto_err <= 1'b1;

      if (strobe_ok)
        word_cnt <= '0;
      else if (write_recv)
        word_cnt <= word_cnt + CW'(1);

      if (last_word)
        block_count <= block_count + 16'd1;

      if (push)
        wr_ptr <= wr_ptr + AW'(1);

      if (pop) begin
        unp_word  <= mem[rd_ptr];
        unp_idx   <= 2'd0;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end else if (unp_accept) begin
        unp_idx <= unp_idx + 2'd1;
        if (unp_idx == 2'd3)
          out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bt_pipe_in_rx.sv
module tb_bt_pipe_in_rx;

  localparam int DEPTH = 64;
  localparam int BW    = 16;

  logic        clk;
  logic        reset;
  logic        ep_write;
  logic [31:0] ep_dataout;
  logic        ep_blockstrobe;
  logic        ep_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  level;
  logic [15:0] block_count;
  logic        proto_err;

  int          checks;
  int          errors;
  logic [7:0]  exp_q[$];
  int          exp_bc;
  int          rdy_mode;
  bit          bub_en;

  bt_pipe_in_rx #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .ep_write(ep_write), .ep_dataout(ep_dataout),
    .ep_blockstrobe(ep_blockstrobe), .ep_ready(ep_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .block_count(block_count), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = random stalls.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every accepted byte must be the next byte the model expects.
  initial begin
    bit         prev_acc;
    int         prev_size;
    logic [7:0] e;
    prev_acc  = 0;
    prev_size = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_acc = 0;
        continue;
      end
      if (bub_en && prev_acc && prev_size >= 8) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bubble: out_valid=%b required 1 (queued bytes %0d)", out_valid, prev_size);
        end
      end
      prev_acc = 0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h, required no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL byte_order: got 0x%02h, required 0x%02h", out_data, e);
          end
        end
        prev_acc = 1;
      end
      prev_size = exp_q.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset          = 1'b1;
    ep_write       = 1'b0;
    ep_blockstrobe = 1'b0;
    repeat (n) tick();
    exp_q.delete();
    exp_bc = 0;
    reset  = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    ep_write   = 1'b1;
    ep_dataout = w;
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    tick();
    ep_write = 1'b0;
  endtask

  task automatic send_block(input bit rand_data, input int max_gap, input int n_words);
    int t;
    logic [31:0] w;
    t = 0;
    while (ep_ready !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    checks++;
    if (ep_ready !== 1'b1) begin
      errors++;
      $display("FAIL ep_ready_wait: ep_ready=%b required 1", ep_ready);
      return;
    end
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    checks++;
    if (ep_ready !== 1'b0) begin
      errors++;
      $display("FAIL ep_ready_drop: ep_ready=%b required 0", ep_ready);
    end
    for (int i = 0; i < n_words; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      w = rand_data ? $urandom : (32'h03020100 + 32'h04040404 * i);
      push_word(w);
    end
    if (n_words == BW) begin
      exp_bc++;
      checks++;
      if (block_count !== 16'(exp_bc)) begin
        errors++;
        $display("FAIL block_count: got %0d required %0d", block_count, exp_bc);
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 7'd0) begin
      errors++;
      $display("FAIL %s_empty: out_valid=%b level=%0d required 0/0", name, out_valid, level);
    end
  endtask

  task automatic test_reset();
    rdy_mode = 1;
    apply_reset(0);
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (ep_ready !== 1'b0 || out_valid !== 1'b0 || level !== 7'd0 || block_count !== 16'd0
        || proto_err !== 1'b0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: ep_ready=%b out_valid=%b level=%0d block_count=%0d proto_err=%b out_data=%0h required all 0",
               ep_ready, out_valid, level, block_count, proto_err, out_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ep_ready !== 1'b1 || level !== 7'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ep_ready=%b level=%0d out_valid=%b required 1/0/0", ep_ready, level, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    rdy_mode = 0;
    repeat (2) tick();
    send_block(0, 0, 5);
    tick();
    checks++;
    if (level !== 7'd4) begin
      errors++;
      $display("FAIL mid_level: got %0d required 4", level);
    end
    apply_reset(2);
    checks++;
    if (level !== 7'd0 || out_valid !== 1'b0 || block_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_flush: level=%0d out_valid=%b block_count=%0d required 0/0/0", level, out_valid, block_count);
    end
    tick();
    checks++;
    if (ep_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: ep_ready=%b required 1", ep_ready);
    end
  endtask

  task automatic test_basic();
    rdy_mode = 1;
    tick();
    send_block(0, 0, BW);
    checks++;
    if (ep_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_reassert: ep_ready=%b required 1", ep_ready);
    end
    drain("basic");
    checks++;
    if (block_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_count: got %0d required 1", block_count);
    end
  endtask

  task automatic test_fill();
    int t;
    rdy_mode = 0;
    repeat (2) tick();
    for (int b = 0; b < 3; b++) send_block(0, 0, BW);
    tick();
    // The unpacker holds one word, so the FIFO shows one fewer.
    checks++;
    if (level !== 7'(exp_q.size() / 4 - 1) || ep_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill3: level=%0d ep_ready=%b required %0d/1", level, ep_ready, exp_q.size() / 4 - 1);
    end
    send_block(0, 0, BW);
    tick();
    checks++;
    if (level !== 7'd63 || ep_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill4: level=%0d ep_ready=%b required 63/0", level, ep_ready);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL fill_noerr: proto_err=%b required 0", proto_err);
    end
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    tick();
    checks++;
    if (proto_err !== 1'b1 || level !== 7'd63 || ep_ready !== 1'b0) begin
      errors++;
      $display("FAIL strobe_not_ready: proto_err=%b level=%0d ep_ready=%b required 1/63/0", proto_err, level, ep_ready);
    end
    rdy_mode = 1;
    t = 0;
    while (ep_ready !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    checks++;
    if (ep_ready !== 1'b1 || level !== 7'(DEPTH - BW)) begin
      errors++;
      $display("FAIL ready_on_space: ep_ready=%b level=%0d required 1/%0d", ep_ready, level, DEPTH - BW);
    end
    drain("fill");
  endtask

  task automatic test_idle_write();
    rdy_mode = 1;
    apply_reset(2);
    tick();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_pre: proto_err=%b required 0", proto_err);
    end
    ep_write   = 1'b1;
    ep_dataout = 32'hDEADBEEF;
    tick();
    ep_write = 1'b0;
    tick();
    checks++;
    if (proto_err !== 1'b1 || level !== 7'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_write: proto_err=%b level=%0d out_valid=%b required 1/0/0", proto_err, level, out_valid);
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    rdy_mode = 2;
    bub_en   = 1;
    for (int b = 0; b < 100; b++) send_block(1, ($urandom_range(0, 3) == 0) ? 2 : 0, BW);
    drain("random");
    bub_en = 0;
    checks++;
    if (block_count !== 16'(exp_bc)) begin
      errors++;
      $display("FAIL random_count: got %0d required %0d", block_count, exp_bc);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    exp_bc         = 0;
    rdy_mode       = 0;
    bub_en         = 0;
    reset          = 1'b1;
    ep_write       = 1'b0;
    ep_dataout     = 32'h0;
    ep_blockstrobe = 1'b0;
    test_reset();
    test_mid_reset();
    test_basic();
    test_fill();
    test_idle_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
